// File: rtl/pattern_sequencer_pkg.sv
// Shared types and constants for the pattern sequencer and its bit-rate divider.
package pattern_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, SETTLE, DONE} state_t;
   localparam int DIV_DEFAULT = 4;
endpackage

// File: rtl/pattern_sequencer_bit_strobe_gen.sv
// Bit-rate divider: counts 0..DIV-1 and flags the last cycle of each serial bit.
module bit_strobe_gen #(
   parameter int DIV = pattern_sequencer_pkg::DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic strobe
);
   localparam int CW = $clog2(DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      strobe = (cnt_q == CW'(DIV - 1));
      cnt_d  = (clear || strobe) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/pattern_sequencer.sv
// Streams up to 8 pattern bits LSB-first into a sequence detector, one bit per
// DIV clocks with a strobe per bit, and counts detector hits during the run.
module pattern_sequencer
   import pattern_sequencer_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] pattern,
   input  logic [2:0] nbits,
   input  logic       det,
   output logic       ser_data,
   output logic       ser_strobe,
   output logic       busy,
   output logic       done,
   output logic [3:0] match_cnt
);
   state_t     state_q, state_d;
   logic [7:0] pat_q, pat_d;
   logic [2:0] nb_q, nb_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] match_q, match_d;
   logic       samp_q, samp_d;
   logic       strobe;
   logic       clear;

   // The divider only runs in SHIFT, so it sits at zero entering every run.
   assign clear = (state_q != SHIFT);

   bit_strobe_gen #(.DIV(DIV)) u_div (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .strobe(strobe)
   );

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      nb_d    = nb_q;
      idx_d   = idx_q;
      match_d = match_q;
      samp_d  = strobe && (state_q == SHIFT);

      // det is looked at one cycle after each strobe, giving the detector time to update.
      if (samp_q && det && (match_q < 4'd8)) match_d = match_q + 4'd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               pat_d   = pattern;
               nb_d    = nbits;
               idx_d   = '0;
               match_d = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (strobe) begin
               if (idx_q == nb_q) state_d = SETTLE;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         SETTLE:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= '0;
         nb_q    <= '0;
         idx_q   <= '0;
         match_q <= '0;
         samp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         nb_q    <= nb_d;
         idx_q   <= idx_d;
         match_q <= match_d;
         samp_q  <= samp_d;
      end
   end

   assign ser_data   = (state_q == SHIFT) && pat_q[idx_q];
   assign ser_strobe = (state_q == SHIFT) && strobe;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign match_cnt  = match_q;
endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: cycle-offset reference model plus directed and random runs.
module tb_pattern_sequencer;
   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pattern = 8'h00;
   logic [2:0] nbits = 3'd0;
   logic       det = 1'b0;
   logic       ser_data, ser_strobe, busy, done;
   logic [3:0] match_cnt;

   pattern_sequencer #(.DIV(DIV)) dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .nbits(nbits),
      .det(det), .ser_data(ser_data), .ser_strobe(ser_strobe), .busy(busy),
      .done(done), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a run is a count of cycles k since the accepted start.
   int         cyc = 0;
   bit         m_run = 0;
   int         m_k = 0, m_len = 0, m_shift = 0, acc_cyc = -1;
   logic [7:0] m_pat = 0;
   int         m_cnt = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_run = 0;
         m_cnt = 0;
      end else if (!m_run) begin
         if (start) begin
            m_run   = 1;
            m_k     = 1;
            m_pat   = pattern;
            m_shift = (int'(nbits) + 1) * DIV;
            m_len   = m_shift + 2;
            m_cnt   = 0;
            acc_cyc = cyc;
         end
      end else begin
         if (det && m_k > DIV && ((m_k - 1) % DIV) == 0 && (m_k - 1) <= m_shift && m_cnt < 8)
            m_cnt++;
         if (m_k == m_len) m_run = 0;
         else              m_k++;
      end
      cyc++;
   end

   // Per-run observations used by the literal expectations.
   int         n_strobe = 0, first_strobe = -1, done_cyc = -1, busy_n = 0;
   logic [7:0] pbits = 0;

   always @(negedge clk) begin
      logic eb, ed, es, edn;
      int   em;
      eb = 0; ed = 0; es = 0; edn = 0; em = m_cnt;
      if (rst) em = 0;
      else if (m_run) begin
         eb  = 1;
         edn = (m_k == m_len);
         if (m_k <= m_shift) begin
            ed = m_pat[(m_k - 1) / DIV];
            es = ((m_k % DIV) == 0);
         end
      end
      chk("busy", int'(busy), int'(eb));
      chk("done", int'(done), int'(edn));
      chk("ser_data", int'(ser_data), int'(ed));
      chk("ser_strobe", int'(ser_strobe), int'(es));
      chk("match_cnt", int'(match_cnt), em);

      if (m_run && !rst && m_k == 1) begin
         n_strobe = 0; first_strobe = -1; done_cyc = -1; busy_n = 0; pbits = 0;
      end
      if (busy) busy_n++;
      if (ser_strobe) begin
         if (first_strobe < 0) first_strobe = cyc;
         if (n_strobe < 8) pbits[n_strobe] = ser_data;
         n_strobe++;
      end
      if (done) done_cyc = cyc;
   end

   int det_mode = 0;
   always @(posedge clk) begin
      #2;
      case (det_mode)
         0:       det = 1'b0;
         1:       det = 1'b1;
         default: det = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_run(input logic [7:0] p, input logic [2:0] n);
      pattern = p;
      nbits   = n;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 200; i++) begin
         if (!m_run && !busy) break;
         tick();
      end
      if (i == 200) chk("wait_idle_timeout", 1, 0);
   endtask

   task automatic goto(input int c);
      for (int i = 0; i < 200 && cyc < c; i++) tick();
   endtask

   int t0;

   initial begin
      // Reset held with start asserted.
      rst = 1'b1; start = 1'b1;
      repeat (3) tick();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ser_data", int'(ser_data), 0);
      chk("rst_strobe", int'(ser_strobe), 0);
      chk("rst_match", int'(match_cnt), 0);
      start = 1'b0;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("idle_after_rst", int'(busy), 0);

      // B2, 8 bits, det low.
      det_mode = 0;
      start_run(8'hB2, 3'd7);
      wait_idle();
      chk("b2_done_lat", done_cyc - acc_cyc, 34);
      chk("b2_first_strobe", first_strobe - acc_cyc, 4);
      chk("b2_n_strobe", n_strobe, 8);
      chk("b2_bits", int'(pbits), 8'hB2);
      chk("b2_busy_cycles", busy_n, 34);

      // det high throughout: count saturates at 8 and holds.
      det_mode = 1;
      start_run(8'h5A, 3'd7);
      wait_idle();
      repeat (3) tick();
      chk("det1_match_hold", int'(match_cnt), 8);
      det_mode = 0;
      start_run(8'h00, 3'd2);
      chk("det1_match_clear", int'(match_cnt), 0);
      wait_idle();

      // Single bit.
      start_run(8'h01, 3'd0);
      wait_idle();
      chk("one_n_strobe", n_strobe, 1);
      chk("one_first_strobe", first_strobe - acc_cyc, 4);
      chk("one_bit", int'(pbits[0]), 1);
      chk("one_done_lat", done_cyc - acc_cyc, 6);

      // Starts during a run and in DONE are ignored; the next IDLE start is taken.
      start_run(8'hC3, 3'd7);
      t0 = acc_cyc;
      goto(t0 + 10);
      start = 1'b1; tick(); start = 1'b0;
      goto(t0 + 34);
      chk("ign_done_seen", int'(done), 1);
      start = 1'b1; pattern = 8'h3C; nbits = 3'd3;
      tick(); tick();
      start = 1'b0;
      chk("ign_accept_cyc", acc_cyc - t0, 35);
      chk("ign_busy_again", int'(busy), 1);
      wait_idle();
      chk("ign_done_lat", done_cyc - acc_cyc, 18);

      // Reset mid-SHIFT.
      start_run(8'hFF, 3'd7);
      t0 = acc_cyc;
      goto(t0 + 13);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ser_data", int'(ser_data), 0);
      chk("mid_rst_strobe", int'(ser_strobe), 0);
      chk("mid_rst_done", int'(done), 0);
      tick();
      rst = 1'b0;
      tick();
      start_run(8'hA5, 3'd5);
      wait_idle();
      chk("post_rst_done_lat", done_cyc - acc_cyc, 2 + 6 * DIV);
      chk("post_rst_n_strobe", n_strobe, 6);
      chk("post_rst_bits", int'(pbits[5:0]), 8'h25);

      // Random runs with random det and stray starts.
      for (int r = 0; r < 30; r++) begin
         det_mode = 2;
         start_run(8'($urandom), 3'($urandom));
         repeat ($urandom_range(0, 20)) begin
            start = 1'($urandom_range(0, 3) == 0);
            pattern = 8'($urandom);
            nbits = 3'($urandom);
            tick();
         end
         start = 1'b0;
         wait_idle();
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors %0d expected 0", n_errors);
      $fatal(1);
   end
endmodule
